// File: rtl/cache_ctrl.sv
// Cache sequencer: lookup, dirty write-back, line fill and replay.
// Optional hit/miss counters are enabled with CACHE_CTRL_STATS_EN.
module cache_ctrl #(
   parameter int ATEG_WIDTH    = 7,
   parameter int AINDEX_WIDTH  = 6,
   parameter int CHANNEL_WIDTH = 3,
   parameter int WOFF_WIDTH    = 2,
   parameter int DATA_WIDTH    = 32,
   parameter int AW = ATEG_WIDTH + AINDEX_WIDTH + WOFF_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cpu_req,
   input  logic                       cpu_we,
   input  logic [AW-1:0]              cpu_addr,
   input  logic [DATA_WIDTH-1:0]      cpu_wdata,
   output logic                       cpu_ack,
   output logic [DATA_WIDTH-1:0]      cpu_rdata,
   output logic [ATEG_WIDTH+AINDEX_WIDTH-1:0] tag_addr,
   output logic                       tag_wr,
   output logic                       tag_md,
   input  logic [ATEG_WIDTH+1:0]      tag_out,
   input  logic [CHANNEL_WIDTH-1:0]   tag_chan,
   input  logic                       tag_hit,
   output logic [CHANNEL_WIDTH+AINDEX_WIDTH+WOFF_WIDTH-1:0] dram_addr,
   output logic                       dram_we,
   output logic [DATA_WIDTH-1:0]      dram_wdata,
   input  logic [DATA_WIDTH-1:0]      dram_rdata,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [AW-1:0]              mem_addr,
   output logic [DATA_WIDTH-1:0]      mem_wdata,
   input  logic [DATA_WIDTH-1:0]      mem_rdata,
   input  logic                       mem_ack
`ifdef CACHE_CTRL_STATS_EN
   ,
   output logic [15:0]                stat_hit,
   output logic [15:0]                stat_miss
`endif
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOOKUP = 3'd1;
   localparam logic [2:0] S_WB_RD  = 3'd2;
   localparam logic [2:0] S_WB_REQ = 3'd3;
   localparam logic [2:0] S_FILL   = 3'd4;
   localparam logic [2:0] S_UPDATE = 3'd5;
   localparam logic [2:0] S_RESP   = 3'd6;

   logic [2:0]               state_q, state_d;
   logic [AW-1:0]            r_addr_q, r_addr_d;
   logic                     r_we_q, r_we_d;
   logic [DATA_WIDTH-1:0]    r_wdata_q, r_wdata_d;
   logic                     refill_q, refill_d;
   logic [CHANNEL_WIDTH-1:0] vch_q, vch_d;
   logic [ATEG_WIDTH-1:0]    vtag_q, vtag_d;
   logic [WOFF_WIDTH-1:0]    wcnt_q, wcnt_d;
   logic                     wb_ent_q, wb_ent_d;
   logic [DATA_WIDTH-1:0]    wbdata_q, wbdata_d;

   logic [AINDEX_WIDTH-1:0]  idx;
   logic [WOFF_WIDTH-1:0]    off;
   logic [ATEG_WIDTH-1:0]    rtag;

   assign idx  = r_addr_q[WOFF_WIDTH +: AINDEX_WIDTH];
   assign off  = r_addr_q[WOFF_WIDTH-1:0];
   assign rtag = r_addr_q[AW-1 -: ATEG_WIDTH];

   always_comb begin
      state_d    = state_q;
      r_addr_d   = r_addr_q;
      r_we_d     = r_we_q;
      r_wdata_d  = r_wdata_q;
      refill_d   = refill_q;
      vch_d      = vch_q;
      vtag_d     = vtag_q;
      wcnt_d     = wcnt_q;
      wb_ent_d   = 1'b0;
      wbdata_d   = wbdata_q;
      cpu_ack    = 1'b0;
      cpu_rdata  = '0;
      tag_addr   = '0;
      tag_wr     = 1'b0;
      tag_md     = 1'b0;
      dram_addr  = '0;
      dram_we    = 1'b0;
      dram_wdata = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      unique case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               r_addr_d  = cpu_addr;
               r_we_d    = cpu_we;
               r_wdata_d = cpu_wdata;
               refill_d  = 1'b0;
               state_d   = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            tag_addr = r_addr_q[AW-1:WOFF_WIDTH];
            if (tag_hit) begin
               dram_addr = {tag_chan, idx, off};
               if (r_we_q) begin
                  dram_we    = 1'b1;
                  dram_wdata = r_wdata_q;
                  tag_wr     = 1'b1;
                  tag_md     = 1'b1;
               end
               state_d = S_RESP;
            end else if (refill_q) begin
               // replay should always hit; abandon the request
               state_d = S_IDLE;
            end else begin
               vch_d   = tag_chan;
               vtag_d  = tag_out[ATEG_WIDTH-1:0];
               wcnt_d  = '0;
               state_d = (tag_out[ATEG_WIDTH+1] && tag_out[ATEG_WIDTH])
                         ? S_WB_RD : S_FILL;
            end
         end
         S_WB_RD: begin
            dram_addr = {vch_q, idx, wcnt_q};
            wb_ent_d  = 1'b1;
            state_d   = S_WB_REQ;
         end
         S_WB_REQ: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {vtag_q, idx, wcnt_q};
            // RAM output is only valid in the first cycle; hold it after
            mem_wdata = wb_ent_q ? dram_rdata : wbdata_q;
            wbdata_d  = mem_wdata;
            if (mem_ack) begin
               wcnt_d  = wcnt_q + 1'b1;
               state_d = (&wcnt_q) ? S_FILL : S_WB_RD;
            end
         end
         S_FILL: begin
            mem_req  = 1'b1;
            mem_addr = {rtag, idx, wcnt_q};
            if (mem_ack) begin
               dram_we    = 1'b1;
               dram_addr  = {vch_q, idx, wcnt_q};
               dram_wdata = mem_rdata;
               wcnt_d     = wcnt_q + 1'b1;
               if (&wcnt_q) state_d = S_UPDATE;
            end
         end
         S_UPDATE: begin
            tag_addr = r_addr_q[AW-1:WOFF_WIDTH];
            tag_wr   = 1'b1;
            refill_d = 1'b1;
            state_d  = S_LOOKUP;
         end
         S_RESP: begin
            cpu_ack   = 1'b1;
            cpu_rdata = dram_rdata;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         r_addr_q  <= '0;
         r_we_q    <= 1'b0;
         r_wdata_q <= '0;
         refill_q  <= 1'b0;
         vch_q     <= '0;
         vtag_q    <= '0;
         wcnt_q    <= '0;
         wb_ent_q  <= 1'b0;
         wbdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         r_addr_q  <= r_addr_d;
         r_we_q    <= r_we_d;
         r_wdata_q <= r_wdata_d;
         refill_q  <= refill_d;
         vch_q     <= vch_d;
         vtag_q    <= vtag_d;
         wcnt_q    <= wcnt_d;
         wb_ent_q  <= wb_ent_d;
         wbdata_q  <= wbdata_d;
      end
   end

`ifdef CACHE_CTRL_STATS_EN
   logic [15:0] hit_q, hit_d, miss_q, miss_d;

   // replayed lookups after a fill are not counted
   always_comb begin
      hit_d  = hit_q;
      miss_d = miss_q;
      if (state_q == S_LOOKUP && !refill_q) begin
         if (tag_hit) begin
            if (hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
         end else if (miss_q != 16'hFFFF) begin
            miss_d = miss_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         hit_q  <= hit_d;
         miss_q <= miss_d;
      end
   end

   assign stat_hit  = hit_q;
   assign stat_miss = miss_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: tag RAM, data RAM and memory models plus a
// flat-memory reference the CPU view must always match.
module tb_cache_ctrl;

   logic        clk;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [14:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic [12:0] tag_addr;
   logic        tag_wr, tag_md;
   logic [8:0]  tag_out;
   logic [2:0]  tag_chan;
   logic        tag_hit;
   logic [10:0] dram_addr;
   logic        dram_we;
   logic [31:0] dram_wdata, dram_rdata;
   logic        mem_req, mem_we;
   logic [14:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ack;
`ifdef CACHE_CTRL_STATS_EN
   logic [15:0] stat_hit, stat_miss;
`endif

   cache_ctrl dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .tag_addr(tag_addr), .tag_wr(tag_wr), .tag_md(tag_md),
      .tag_out(tag_out), .tag_chan(tag_chan), .tag_hit(tag_hit),
      .dram_addr(dram_addr), .dram_we(dram_we),
      .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_CTRL_STATS_EN
      , .stat_hit(stat_hit), .stat_miss(stat_miss)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp;
   int n_err;

   function automatic logic [31:0] init_word(input logic [14:0] a);
      return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // flat reference memory: what the CPU must see
   bit        gold_v [32768];
   bit [31:0] gold   [32768];

   function automatic logic [31:0] gold_rd(input logic [14:0] a);
      return gold_v[a] ? gold[a] : init_word(a);
   endfunction

   // tag RAM model: 64 sets x 8 ways, FIFO replacement
   bit       tv [64][8];
   bit       td [64][8];
   bit [6:0] tt [64][8];
   bit [2:0] fifo [64];
   logic [5:0] tm_idx;
   logic [6:0] tm_tag;
   logic       hit_l;
   logic [2:0] ch_l;
   int         tw_cnt;
   logic       tw_md;

   always_comb begin
      tm_idx = tag_addr[5:0];
      tm_tag = tag_addr[12:6];
      hit_l  = 1'b0;
      ch_l   = fifo[tm_idx];
      for (int w = 0; w < 8; w++)
         if (!hit_l && tv[tm_idx][w] && tt[tm_idx][w] == tm_tag) begin
            hit_l = 1'b1;
            ch_l  = w[2:0];
         end
      tag_hit  = hit_l;
      tag_chan = ch_l;
      tag_out  = {tv[tm_idx][ch_l], td[tm_idx][ch_l], tt[tm_idx][ch_l]};
   end

   always @(posedge clk) begin
      if (tag_wr) begin
         tw_cnt <= tw_cnt + 1;
         tw_md  <= tag_md;
         if (tag_hit) td[tm_idx][tag_chan] <= tag_md;
         else begin
            tv[tm_idx][fifo[tm_idx]] <= 1'b1;
            td[tm_idx][fifo[tm_idx]] <= tag_md;
            tt[tm_idx][fifo[tm_idx]] <= tm_tag;
            fifo[tm_idx] <= fifo[tm_idx] + 3'd1;
         end
      end
   end

   // data RAM model, synchronous read
   bit [31:0] dram [2048];
   int        dwe_cnt;

   always @(posedge clk) begin
      if (dram_we) begin
         dram[dram_addr] <= dram_wdata;
         dwe_cnt <= dwe_cnt + 1;
      end
      dram_rdata <= dram[dram_addr];
   end

   // external memory with random ack delay
   bit        ext_v [32768];
   bit [31:0] ext   [32768];
   logic      auto_ack, man_ack;
   bit        mem_auto;
   int        max_dly;
   int        dly;
   logic [46:0] wb_q [$];
   logic [14:0] rd_q [$];

   assign mem_ack = auto_ack | man_ack;

   always @(posedge clk) begin
      auto_ack <= 1'b0;
      if (reset) dly <= 0;
      else if (mem_auto && mem_req && auto_ack !== 1'b1) begin
         if (dly == 0) begin
            auto_ack <= 1'b1;
            if (mem_we) begin
               ext[mem_addr]   <= mem_wdata;
               ext_v[mem_addr] <= 1'b1;
               wb_q.push_back({mem_addr, mem_wdata});
            end else begin
               mem_rdata <= ext_v[mem_addr] ? ext[mem_addr]
                                            : init_word(mem_addr);
               rd_q.push_back(mem_addr);
            end
            dly <= int'($urandom_range(max_dly, 0));
         end else dly <= dly - 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   int wb_rp;

   task automatic drain_wb();
      while (wb_rp < wb_q.size()) begin
         chk("wb_data", wb_q[wb_rp][31:0], gold_rd(wb_q[wb_rp][46:32]));
         wb_rp++;
      end
   endtask

   task automatic do_req(input bit we, input logic [14:0] a,
                         input logic [31:0] wd, input bit stray,
                         output logic [31:0] rd, output int lat);
      bit done;
      done = 1'b0;
      lat  = 0;
      rd   = '0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      while (!done && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
         if (cpu_ack) begin
            done = 1'b1;
            rd = cpu_rdata;
            cpu_req = 1'b0;
         end else if (stray) begin
            cpu_req   = 1'($urandom);
            cpu_we    = 1'($urandom);
            cpu_addr  = 15'($urandom);
            cpu_wdata = $urandom;
         end
      end
      chk("req_done", 32'(done), 32'd1);
      cpu_req = 1'b0;
      @(posedge clk); #1;
      drain_wb();
      if (we) begin
         gold[a]   = wd;
         gold_v[a] = 1'b1;
      end else chk("rdata", rd, gold_rd(a));
   endtask

   initial begin
      logic [31:0] rd;
      int lat, rs, ws, tw0, d0, k;
      logic [14:0] a;
      clk = 0; reset = 1; cpu_req = 0; cpu_we = 0;
      cpu_addr = '0; cpu_wdata = '0; man_ack = 0;
      mem_auto = 1; max_dly = 0;
      n_cmp = 0; n_err = 0; wb_rp = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", 32'(cpu_ack), 0);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_tag_wr", 32'(tag_wr), 0);
      chk("rst_dram_we", 32'(dram_we), 0);
      chk("rst_buses", 32'(mem_addr) | 32'(dram_addr) | 32'(tag_addr), 0);
      @(negedge clk); reset = 0;

      // cold read miss
      rs = rd_q.size(); tw0 = tw_cnt;
      do_req(0, 15'h0004, 0, 0, rd, lat);
      chk("fill_cnt", 32'(rd_q.size() - rs), 4);
      for (int i = 0; i < 4; i++) chk("fill_addr", 32'(rd_q[rs+i]), 32'(4+i));
      chk("tag_wr_cnt", 32'(tw_cnt - tw0), 1);
      chk("tag_md_fill", 32'(tw_md), 0);

      // read hit
      rs = rd_q.size();
      do_req(0, 15'h0004, 0, 0, rd, lat);
      chk("hit_lat", 32'(lat), 2);
      chk("hit_no_mem", 32'(rd_q.size() - rs), 0);

      // write hit, then evict that dirty line
      do_req(1, 15'h0005, 32'hDEADBEEF, 0, rd, lat);
      chk("wr_hit_lat", 32'(lat), 2);
      chk("wr_dirty", 32'(td[1][0]), 1);
      for (int t = 1; t < 8; t++) begin
         a = 15'((t << 8) | 4);
         do_req(0, a, 0, 0, rd, lat);
      end
      ws = wb_q.size(); rs = rd_q.size();
      do_req(0, 15'h0804, 0, 0, rd, lat);
      chk("wb_cnt", 32'(wb_q.size() - ws), 4);
      for (int i = 0; i < 4; i++)
         chk("wb_addr", 32'(wb_q[ws+i][46:32]), 32'(4+i));
      chk("wb_word1", wb_q[ws+1][31:0], 32'hDEADBEEF);
      chk("refill_addr", 32'(rd_q[rs]), 32'h0804);
      do_req(0, 15'h0005, 0, 0, rd, lat);

      // random traffic with stray requests outside IDLE
      max_dly = 5;
      for (int n = 0; n < 60; n++) begin
         a = {3'b0, 4'($urandom), 6'($urandom_range(3, 0)), 2'($urandom)};
         do_req(1'($urandom), a, $urandom, 1, rd, lat);
      end

      // reset during write-back
      max_dly = 0;
      for (int t = 0; t < 8; t++)
         do_req(1, 15'((t << 8) | (9 << 2)), $urandom, 0, rd, lat);
      mem_auto = 0;
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 15'((8 << 8) | (9 << 2));
      k = 0;
      while (k < 200 && !(mem_req && mem_we)) begin
         @(posedge clk); #1; k++;
      end
      chk("wb_seen", 32'(mem_req & mem_we), 1);
      #2 reset = 1;
      #1 chk("rst_async_req", 32'(mem_req), 0);
      cpu_req = 0;
      @(posedge clk); #1;
      chk("rst_no_ack", 32'(cpu_ack), 0);
      @(negedge clk); reset = 0;
      d0 = dwe_cnt;
      @(negedge clk); man_ack = 1;
      @(negedge clk); man_ack = 0;
      @(posedge clk); #1;
      chk("late_ack_dram_we", 32'(dwe_cnt - d0), 0);
      chk("late_ack_mem_req", 32'(mem_req), 0);
      mem_auto = 1;
      do_req(0, 15'((7 << 8) | (9 << 2)), 0, 0, rd, lat);
      chk("post_rst_lat", 32'(lat), 2);

`ifdef CACHE_CTRL_STATS_EN
      @(negedge clk); reset = 1;
      @(negedge clk); reset = 0;
      for (int t = 0; t < 3; t++)
         do_req(0, 15'((t << 8) | (20 << 2)), 0, 0, rd, lat);
      for (int t = 0; t < 5; t++)
         do_req(0, 15'(((t % 3) << 8) | (20 << 2) | 1), 0, 0, rd, lat);
      chk("stat_miss", 32'(stat_miss), 3);
      chk("stat_hit", 32'(stat_hit), 5);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
